// File: rtl/lse_clut_pkg.sv
// lse_clut_pkg: shared CLUT widths, data types and the in-flight lookup tag record
package lse_clut_pkg;
    localparam int CLUT_ADDR_WIDTH  = 4;
    localparam int CLUT_ENTRY_WIDTH = 10;
    localparam int CLUT_ENTRIES     = 1 << CLUT_ADDR_WIDTH;
    // wide enough for the largest supported lane count (8)
    localparam int MAX_ID_WIDTH     = 3;
    typedef logic [CLUT_ADDR_WIDTH-1:0]  clut_addr_t;
    typedef logic [CLUT_ENTRY_WIDTH-1:0] clut_corr_t;
    typedef struct packed {
        logic                    v;
        logic [MAX_ID_WIDTH-1:0] id;
    } clut_tag_t;
endpackage

// File: rtl/lse_clut_arbiter_if.sv
// lse_clut_arbiter_if: lane request/response bundle plus the CLUT lookup port
interface lse_clut_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 4,
    parameter int ENTRY_WIDTH = 10
) ();
    localparam int ID_WIDTH = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic                          clut_valid_in;
    logic [ADDR_WIDTH-1:0]         clut_address;
    logic                          clut_valid_out;
    logic [ENTRY_WIDTH-1:0]        clut_correction;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [ID_WIDTH-1:0]           rsp_id;
    logic [ENTRY_WIDTH-1:0]        rsp_correction;
    modport master (
        output req_valid, req_addr, clut_valid_out, clut_correction,
        input  req_ready, clut_valid_in, clut_address, rsp_valid, rsp_id, rsp_correction
    );
    modport slave (
        input  req_valid, req_addr, clut_valid_out, clut_correction,
        output req_ready, clut_valid_in, clut_address, rsp_valid, rsp_id, rsp_correction
    );
endinterface

// File: rtl/lse_rr_arbiter.sv
// lse_rr_arbiter: combinational round-robin pick starting at ptr, one-hot grant plus index
module lse_rr_arbiter #(
    parameter  int NUM_REQ  = 4,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] id
);
    logic [ID_WIDTH-1:0] idx;
    // scan downward in offset so the requester closest to ptr is the last writer
    always_comb begin
        grant = '0;
        id    = '0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                grant = NUM_REQ'(1) << idx;
                id    = idx;
            end
        end
    end
endmodule

// File: rtl/lse_clut_arbiter.sv
// lse_clut_arbiter: round-robin sharing of one CLUT lookup port across NUM_REQ lanes
// Optional per-lane saturating grant counters: define LSE_CLUT_ARB_STATS_EN
module lse_clut_arbiter
    import lse_clut_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int ADDR_WIDTH   = CLUT_ADDR_WIDTH,
    parameter  int ENTRY_WIDTH  = CLUT_ENTRY_WIDTH,
    parameter  int CLUT_LATENCY = 1,
    localparam int ID_WIDTH     = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arb_en,
    lse_clut_arbiter_if.slave       bus,
    output logic                    busy,
    output logic                    err,
    output logic [NUM_REQ*16-1:0]   grant_count
);
    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] issue_addr;
    clut_tag_t             tag [CLUT_LATENCY];
    clut_tag_t             tag_last;
    logic                  hit;
    logic                  tag_busy;

    lse_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (bus.req_valid & {NUM_REQ{arb_en & ~rst}}),
        .ptr   (rr_ptr),
        .grant (grant),
        .id    (grant_id)
    );

    // forward the winning lane's address; zero when nothing is issued
    always_comb begin
        issue      = 1'b0;
        issue_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] & bus.req_valid[i]) begin
                issue      = 1'b1;
                issue_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign bus.req_ready     = grant;
    assign bus.clut_valid_in = issue;
    assign bus.clut_address  = issue_addr;

    // move priority to the lane after the one just served
    always_ff @(posedge clk) begin
        if (rst) rr_ptr <= '0;
        else if (issue) rr_ptr <= (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end

    // tag shift register lines each issue up with its CLUT result
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < CLUT_LATENCY; s++) tag[s] <= '0;
        end else begin
            tag[0] <= '{v: issue, id: MAX_ID_WIDTH'(grant_id)};
            for (int s = 1; s < CLUT_LATENCY; s++) tag[s] <= tag[s-1];
        end
    end

    assign tag_last = tag[CLUT_LATENCY-1];
    assign hit      = tag_last.v & bus.clut_valid_out;

    // register the routed response and latch any valid/tag disagreement
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_valid      <= '0;
            bus.rsp_id         <= '0;
            bus.rsp_correction <= '0;
            err                <= 1'b0;
        end else begin
            bus.rsp_valid <= hit ? NUM_REQ'(1) << tag_last.id : '0;
            if (hit) begin
                bus.rsp_id         <= ID_WIDTH'(tag_last.id);
                bus.rsp_correction <= ENTRY_WIDTH'(bus.clut_correction);
            end
            err <= err | (bus.clut_valid_out != tag_last.v);
        end
    end

    // any live tag stage keeps the block busy
    always_comb begin
        tag_busy = 1'b0;
        for (int s = 0; s < CLUT_LATENCY; s++) tag_busy = tag_busy | tag[s].v;
    end

    assign busy = tag_busy | (|bus.rsp_valid);

`ifdef LSE_CLUT_ARB_STATS_EN
    logic [15:0] cnt [NUM_REQ];
    // count accepts per lane, sticking at all-ones
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) cnt[i] <= '0;
            else if (bus.req_valid[i] & grant[i] & (cnt[i] != 16'hFFFF)) cnt[i] <= cnt[i] + 16'd1;
        end
    end
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        assign grant_count[i*16 +: 16] = cnt[i];
    end
`else
    assign grant_count = '0;
`endif

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_chk
        // a lane still waiting for its grant must keep its address steady
        assert property (@(posedge clk) disable iff (rst)
            bus.req_valid[i] && !bus.req_ready[i] |=>
            !bus.req_valid[i] || $stable(bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]));
    end
endmodule
